// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data memory arbiter, CPU priority with starvation-forced DMA grants
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  logic sat, grant_dma;
  assign sat = starve_cnt == SMAX;
  assign grant_dma = dma_req & (~cpu_req | sat) & ~reset;
  assign dma_gnt = grant_dma;
  assign cpu_stall = cpu_req & grant_dma;
  assign cpu_rdata = mem_rdata;
  always_comb begin
    mem_we = grant_dma ? dma_we : cpu_we & cpu_req & ~reset;
    mem_addr = grant_dma ? dma_addr : cpu_addr;
    mem_wdata = grant_dma ? dma_wdata : cpu_wdata;
  end
  // the counter never exceeds SMAX, so "not saturated" is the below-limit test
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata <= '0;
    end else begin
      starve_cnt <= grant_dma ? 4'd0 : (dma_req & ~sat) ? starve_cnt + 4'd1 : ~dma_req ? 4'd0 : starve_cnt;
      dma_rvalid <= grant_dma & ~dma_we;
      if (grant_dma & ~dma_we) dma_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table-driven bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, dma_gnt, dma_rvalid, mem_we;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata;
  logic b_cpu_stall, b_dma_gnt, b_dma_rvalid, b_mem_we;
  logic [31:0] b_mem_rdata = 32'h5a5a5a5a;
  logic [31:0] mem [256];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.STARVE_MAX(0)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(b_dma_gnt), .dma_rdata(b_dma_rdata), .dma_rvalid(b_dma_rvalid),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic s, g, w, rc; logic [31:0] rd;
    logic rv; logic [31:0] rdat;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic cr, cw, logic [31:0] ca, cd, logic dr, dw, logic [31:0] da, dd,
                              logic s, g, w, rc, logic [31:0] rd, logic rv, logic [31:0] rdat);
    vec_t v;
    v = '{cr, cw, ca, cd, dr, dw, da, dd, s, g, w, rc, rd, rv, rdat};
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic cr, cw, input logic [31:0] ca, cd, input logic dr, dw, input logic [31:0] da, dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic run(input vec_t v, input int k);
    drive(v.cr, v.cw, v.ca, v.cd, v.dr, v.dw, v.da, v.dd);
    #1;
    chk($sformatf("v%0d cpu_stall", k), 32'(cpu_stall), 32'(v.s));
    chk($sformatf("v%0d dma_gnt", k), 32'(dma_gnt), 32'(v.g));
    chk($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(v.w));
    if (v.rc) chk($sformatf("v%0d cpu_rdata", k), cpu_rdata, v.rd);
    chk($sformatf("v%0d dma_rvalid", k), 32'(dma_rvalid), 32'(v.rv));
    if (v.rv) chk($sformatf("v%0d dma_rdata", k), dma_rdata, v.rdat);
    @(negedge clk);
  endtask

  initial begin
    drive(1, 1, 32'h10, 32'h1234, 1, 1, 32'h10, 32'h5678);
    // CPU only: store then load
    tbl.push_back(mk(1, 1, 32'h10, 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hdeadbeef, 0, 0));
    // DMA only read, response one cycle later
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hdeadbeef));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // sustained contention: 4 CPU grants then 1 forced DMA grant
    for (int i = 0; i < 10; i++) begin
      logic f;
      f = (i == 4) || (i == 9);
      tbl.push_back(mk(1, 0, 32'h10, 0, 1, 0, 32'h10, 0, f, f, 0, ~f, 32'hdeadbeef, i == 5, 32'hdeadbeef));
    end
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hdeadbeef));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // pending DMA write forced against a CPU store to the same address
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 32'h24, 0, 1, 1, 32'h20, 32'h11111111, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h20, 32'h22222222, 1, 1, 32'h20, 32'h11111111, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h20, 32'h22222222, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11111111, 0, 0));
    tbl.push_back(mk(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst dma_gnt", 32'(dma_gnt), 0);
    chk("rst cpu_stall", 32'(cpu_stall), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst dma_rvalid", 32'(dma_rvalid), 0);
    chk("rst dma_rdata", dma_rdata, 0);
    chk("rst b dma_gnt", 32'(b_dma_gnt), 0);
    reset = 1'b0;
    foreach (tbl[k]) run(tbl[k], k);

    // STARVE_MAX=0 instance: DMA wins every contended cycle
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h10, 0, 1, 0, 32'h10, 0);
      #1;
      chk($sformatf("sm0 c%0d dma_gnt", i), 32'(b_dma_gnt), 1);
      chk($sformatf("sm0 c%0d cpu_stall", i), 32'(b_cpu_stall), 1);
      @(negedge clk);
    end
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("sm0 drop cpu_stall", 32'(b_cpu_stall), 0);
    chk("sm0 drop dma_gnt", 32'(b_dma_gnt), 0);
    @(negedge clk);

    // async reset mid-cycle with starve_cnt=3 and a granted DMA write
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h10, 0, 1, 0, 32'h10, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 1, 1, 32'h30, 32'h33333333);
    #1;
    chk("pre-rst dma_gnt", 32'(dma_gnt), 1);
    chk("pre-rst mem_we", 32'(mem_we), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid-rst dma_gnt", 32'(dma_gnt), 0);
    chk("mid-rst mem_we", 32'(mem_we), 0);
    chk("mid-rst cpu_stall", 32'(cpu_stall), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h10, 0, 1, 0, 32'h10, 0);
      #1;
      chk($sformatf("post-rst c%0d dma_gnt", i), 32'(dma_gnt), 32'(i == 4));
      chk($sformatf("post-rst c%0d cpu_stall", i), 32'(cpu_stall), 32'(i == 4));
      chk($sformatf("post-rst c%0d dma_rvalid", i), 32'(dma_rvalid), 0);
      @(negedge clk);
    end

    // reset during a granted DMA read suppresses the response
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
    #1;
    chk("rd-rst pre dma_gnt", 32'(dma_gnt), 1);
    #2 reset = 1'b1;
    #1;
    chk("rd-rst mid dma_gnt", 32'(dma_gnt), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rd-rst dma_rvalid", 32'(dma_rvalid), 0);
    chk("rd-rst dma_rdata", dma_rdata, 0);
    @(negedge clk);
    #1;
    chk("rd-rst late dma_rvalid", 32'(dma_rvalid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single-port data memory between the pipeline MEM stage (CPU port) and a secondary requester such as a loader or DMA engine (DMA port). The CPU has default priority. A saturating starvation counter forces a DMA grant after STARVE_MAX consecutive losing cycles, and the CPU is stalled for that cycle. The block sits between the MEM-stage pipeline register outputs and the data memory. Its cpu_stall output feeds the hazard unit.

Parameters:
ADDR_W, 32, address width of both ports and memory
DATA_W, 32, data width
STARVE_MAX, 4, number of consecutive denied DMA cycles before a forced DMA grant; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  MEM stage performs a load or store this cycle
cpu_we  input  1  CPU store (MemWriteM)
cpu_addr  input  ADDR_W  CPU address (ALUResultM)
cpu_wdata  input  DATA_W  CPU store data (WriteDataM)
cpu_rdata  output  DATA_W  CPU load data (ReadDataM)
cpu_stall  output  1  CPU access not granted this cycle; freeze PC and pipeline registers
dma_req  input  1  DMA access request, held until dma_gnt
dma_we  input  1  DMA write
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  DATA_W  DMA write data
dma_gnt  output  1  DMA access accepted this cycle
dma_rdata  output  DATA_W  registered DMA read data
dma_rvalid  output  1  dma_rdata valid; one-cycle pulse
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data (combinational read; write occurs on clk edge)

Behaviour:
- State:
  - starve_cnt: 4 bits, saturating at STARVE_MAX.
  - dma_rvalid register.
  - dma_rdata register.
- Grant logic (combinational):
  - grant_dma = dma_req & (~cpu_req | starve_cnt == STARVE_MAX) & ~reset
  - dma_gnt = grant_dma
  - cpu_stall = cpu_req & grant_dma
- Memory mux:
  - When grant_dma is high, mem_we/mem_addr/mem_wdata = dma_we/dma_addr/dma_wdata.
  - Otherwise they take the CPU signals, with mem_we = cpu_we & cpu_req.
  - mem_we is forced to 0 while reset is high.
- cpu_rdata = mem_rdata at all times. It is meaningful only when cpu_req=1 and cpu_stall=0, i.e. zero added latency for CPU loads.
- Counter update on the rising clk edge, first matching rule applies:
  - grant_dma -> starve_cnt = 0
  - dma_req & starve_cnt < STARVE_MAX -> starve_cnt + 1
  - ~dma_req -> starve_cnt = 0
  - otherwise starve_cnt holds.
- DMA read return: at an edge where grant_dma=1 and dma_we=0, capture dma_rdata <= mem_rdata and set dma_rvalid=1 for exactly one cycle. Otherwise dma_rvalid=0 and dma_rdata holds. Read latency is 1 cycle after dma_gnt.
- DMA write completes at the edge of the cycle where dma_gnt=1. There is no response for writes.
- STARVE_MAX=0: DMA wins every cycle it requests and the CPU stalls for each conflict.
- Fairness:
  - After a forced DMA grant, starve_cnt=0, so the CPU (held by the stall) wins the next cycle.
  - Under sustained contention the pattern is STARVE_MAX CPU grants followed by 1 DMA grant.
- Simultaneous events:
  - A CPU store and a DMA write to the same address never occur in the same cycle, since only one is granted.
  - No forwarding between ports.
- Reset, asserted at any time, including mid-request:
  - starve_cnt=0, dma_rvalid=0, dma_rdata=0.
  - dma_gnt=0, cpu_stall=0, mem_we=0 immediately (asynchronous).
  - A DMA read granted in the same cycle reset asserts produces no dma_rvalid.
- The requester must hold dma_req, dma_we, dma_addr and dma_wdata stable until dma_gnt. The arbiter does not latch DMA requests.

Test Plan:
1. CPU only: cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF; then a load from 0x10 -> cpu_stall=0 both cycles and cpu_rdata=0xDEADBEEF in the load cycle. dma_gnt stays 0.
2. DMA only: dma_req=1, dma_we=0, addr 0x10 -> dma_gnt=1 in the same cycle, then next cycle dma_rvalid=1 with dma_rdata=0xDEADBEEF. dma_rvalid=0 the cycle after.
3. Contention, STARVE_MAX=4: cpu_req and dma_req held high for 10 cycles -> CPU granted cycles 0-3, dma_gnt=1 and cpu_stall=1 in cycle 4, CPU granted cycles 5-8, DMA again in cycle 9.
4. STARVE_MAX=0 with both requesting -> dma_gnt=1 and cpu_stall=1 every cycle while dma_req=1. When dma_req drops, cpu_stall=0 in that same cycle.
5. DMA write forced during a pending CPU store: DMA writes 0x11111111 to 0x20 while the CPU holds a store of 0x22222222 to 0x20 -> the DMA write occurs in the stall cycle, the CPU store next cycle, and a final read of 0x20 returns 0x22222222.
6. Reset asserted asynchronously mid-cycle with dma_req=1, starve_cnt=3 -> dma_gnt and mem_we go to 0 immediately. After reset release, starve_cnt restarts from 0 (DMA is forced only after 4 more contended cycles) and no dma_rvalid pulse appears.
